// File: rtl/gigatron_pkg.sv
// Shared constants and the trace entry layout for the Gigatron trace capture block.
package gigatron_pkg;

  // Capture modes.
  localparam int unsigned MODE_ON_CHANGE = 0;
  localparam int unsigned MODE_EVERY     = 1;

  // Default compare mask: vsync/hsync bits of the out port.
  localparam logic [7:0] SYNC_MASK = 8'hC0;

  // Default field widths of a trace entry.
  localparam int unsigned TRACE_DATA_W  = 8;
  localparam int unsigned TRACE_PC_W    = 16;
  localparam int unsigned TRACE_STAMP_W = 16;

  // One trace entry, most significant field first.
  typedef struct packed {
    logic [TRACE_DATA_W-1:0]  out;
    logic [TRACE_DATA_W-1:0]  xout;
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_entry_t;

endpackage

// File: rtl/gigatron_sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers and a flush input.
module gigatron_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AddrW:0]   count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Pointer next-state; flush wins over any push or pop.
  always_comb begin
    wptr_d = wptr_q + (AddrW + 1)'(push_ok);
    rptr_d = rptr_q + (AddrW + 1)'(pop_ok);
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/gigatron_trace_capture.sv
// Watches the CPU out/xout/PC, timestamps qualifying cycles and queues them for a host to drain.
module gigatron_trace_capture
  import gigatron_pkg::*;
#(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          PC_W    = 16,
  parameter int unsigned          STAMP_W = 16,
  parameter int unsigned          DEPTH   = 16,
  parameter int unsigned          MODE    = MODE_ON_CHANGE,
  parameter logic [DATA_W-1:0]    MASK    = DATA_W'(SYNC_MASK),
  localparam int unsigned         CntW    = $clog2(DEPTH) + 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [DATA_W-1:0]  i_out,
  input  logic [DATA_W-1:0]  i_xout,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [DATA_W-1:0]  o_rd_out,
  output logic [DATA_W-1:0]  o_rd_xout,
  output logic [PC_W-1:0]    o_rd_pc,
  output logic [STAMP_W-1:0] o_rd_stamp,
  output logic [CntW-1:0]    o_count,
  output logic               o_overflow,
  output logic [15:0]        o_drop_count
);

  // Same layout as trace_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0]  out;
    logic [DATA_W-1:0]  xout;
    logic [PC_W-1:0]    pc;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [DATA_W-1:0]  prev_out_q, prev_out_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_count_q, drop_count_d;

  logic   masked_change;
  logic   evt;
  logic   pop;
  logic   push;
  logic   drop;
  logic   fifo_empty;
  logic   fifo_full;
  entry_t wr_entry;
  entry_t rd_entry;

  // Event detection and FIFO handshake.
  always_comb begin
    masked_change = |((i_out ^ prev_out_q) & MASK);
    evt           = i_enable & ((MODE == MODE_EVERY) ? 1'b1 : masked_change);
    pop           = o_rd_valid & i_rd_ready;
    push          = evt & ~i_clear;
    drop          = evt & fifo_full & ~pop & ~i_clear;
    wr_entry      = '{out: i_out, xout: i_xout, pc: i_pc, stamp: stamp_q};
  end

  gigatron_sync_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .clear_i (i_clear),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (o_count)
  );

  assign o_rd_valid   = ~fifo_empty;
  assign o_rd_out     = rd_entry.out;
  assign o_rd_xout    = rd_entry.xout;
  assign o_rd_pc      = rd_entry.pc;
  assign o_rd_stamp   = rd_entry.stamp;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_count_q;

  // Timestamp, previous-out tracking and overflow accounting next-state.
  always_comb begin
    stamp_d      = stamp_q + STAMP_W'(1);
    prev_out_d   = i_enable ? i_out : prev_out_q;
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    if (i_clear) begin
      stamp_d      = '0;
      prev_out_d   = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stamp_q      <= '0;
      prev_out_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      stamp_q      <= stamp_d;
      prev_out_q   <= prev_out_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule
